// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage MIPS core: load-use stalls, taken-branch flushes,
// and a front-end freeze while a multi-cycle mult/div occupies EX.
module hazard_stall_controller #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             ID_EX_md_start,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             ID_EX_hold,
  output logic             EX_MEM_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  md_state_t  state, state_next;
  logic [3:0] md_cnt, md_cnt_next;
  logic       luse;
  logic       freeze;

  assign luse = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  // A mult/div trigger is only honoured from IDLE; in MD_DONE the same instruction is advancing.
  assign freeze = !rst && (((state == IDLE) && ID_EX_md_start) || (state == MD_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      md_cnt      <= 4'd0;
      stall_count <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
      if (!pc_write && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next  = state;
    md_cnt_next = md_cnt;
    unique case (state)
      IDLE: begin
        if (ID_EX_md_start) begin
          state_next  = MD_WAIT;
          md_cnt_next = MD_LOAD;
        end
      end
      MD_WAIT: begin
        md_cnt_next = md_cnt - 4'd1;
        if (md_cnt == 4'd1)
          state_next = MD_DONE;
      end
      MD_DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next  = IDLE;
        md_cnt_next = 4'd0;
      end
    endcase
  end

  // Freeze beats load-use, which in turn beats a branch flush.
  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    ID_EX_hold    = 1'b0;
    EX_MEM_bubble = 1'b0;
    md_busy       = !rst && (state != IDLE);
    if (!rst) begin
      if (freeze) begin
        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EX_hold    = 1'b1;
        EX_MEM_bubble = 1'b1;
      end else if (luse) begin
        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EX_bubble  = 1'b1;
      end else if (branch_taken) begin
        IF_ID_flush   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (MD_CYCLES=4, CNT_W=4).
module tb_hazard_stall_controller;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rt;
  logic             ID_EX_md_start;
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             branch_taken;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             ID_EX_hold;
  logic             EX_MEM_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_count;

  int nCompared   = 0;
  int nMismatched = 0;

  // Control vector order: pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_hold, EX_MEM_bubble, md_busy
  localparam logic [6:0] CTL_RUN    = 7'b1100000;
  localparam logic [6:0] CTL_LUSE   = 7'b0001000;
  localparam logic [6:0] CTL_FLUSH  = 7'b1110000;
  localparam logic [6:0] CTL_MDGO   = 7'b0000110;
  localparam logic [6:0] CTL_MDWAIT = 7'b0000111;
  localparam logic [6:0] CTL_MDDONE = 7'b1100001;
  localparam logic [6:0] CTL_DONELU = 7'b0001001;

  hazard_stall_controller #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_Rt       (ID_EX_Rt),
    .ID_EX_md_start (ID_EX_md_start),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .branch_taken   (branch_taken),
    .pc_write       (pc_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble),
    .ID_EX_hold     (ID_EX_hold),
    .EX_MEM_bubble  (EX_MEM_bubble),
    .md_busy        (md_busy),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [6:0] exp);
    checkOutput(tag, {25'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
                      ID_EX_hold, EX_MEM_bubble, md_busy}, {25'd0, exp});
  endtask

  task automatic checkCount(input string tag, input int exp);
    checkOutput(tag, {{(32-CNT_W){1'b0}}, stall_count}, 32'(exp));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic mr, input logic [4:0] ex_rt, input logic md,
                               input logic [4:0] rs, input logic [4:0] rt, input logic br);
    ID_EX_MemRead  = mr;
    ID_EX_Rt       = ex_rt;
    ID_EX_md_start = md;
    IF_ID_Rs       = rs;
    IF_ID_Rt       = rt;
    branch_taken   = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 5'd8, 1'b1, 5'd8, 5'd0, 1'b1);
    checkCtl("rst_outputs_released", CTL_RUN);
    tick();
    tick();
    checkCount("rst_count", 0);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    checkCtl("post_rst_idle", CTL_RUN);
    checkCount("post_rst_count", 0);

    // Load-use via Rs, then the r0 exception, then via Rt
    applyStimulus(1'b1, 5'd8, 1'b0, 5'd8, 5'd3, 1'b0);
    checkCtl("luse_rs", CTL_LUSE);
    tick();
    checkCount("luse_rs_count", 1);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    checkCtl("luse_r0_no_stall", CTL_RUN);
    tick();
    checkCount("luse_r0_count", 1);
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd3, 5'd9, 1'b0);
    checkCtl("luse_rt", CTL_LUSE);
    tick();
    checkCount("luse_rt_count", 2);
    applyStimulus(1'b0, 5'd9, 1'b0, 5'd9, 5'd9, 1'b0);
    checkCtl("no_memread_no_stall", CTL_RUN);
    tick();

    // Branch alone flushes; branch with load-use stalls instead
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 1'b1);
    checkCtl("branch_flush", CTL_FLUSH);
    tick();
    checkCount("branch_count", 2);
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd5, 5'd2, 1'b1);
    checkCtl("branch_with_luse", CTL_LUSE);
    tick();
    checkCount("branch_luse_count", 3);

    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    checkCount("rst2_count", 0);

    // Mult/div held 5 cycles: 4 frozen, then MD_DONE; luse/branch ignored in MD_WAIT
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    checkCtl("md_detect", CTL_MDGO);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    checkCtl("md_wait1", CTL_MDWAIT);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 1'b1);
    checkCtl("md_wait_priority", CTL_MDWAIT);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    checkCtl("md_wait3", CTL_MDWAIT);
    tick();
    checkCount("md_count_after_freeze", 4);
    checkCtl("md_done", CTL_MDDONE);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    checkCtl("md_back_idle", CTL_RUN);
    checkCount("md_count_final", 4);

    // Reset during MD_WAIT
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    checkCtl("md2_wait", CTL_MDWAIT);
    rst = 1'b1;
    #1;
    checkCtl("md2_rst_release", CTL_RUN);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    checkCtl("md2_rst_idle", CTL_RUN);
    checkCount("md2_rst_count", 0);

    // Back-to-back: md_start ignored in MD_DONE, retriggers from IDLE
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkCtl("b2b_done_ignores_start", CTL_MDDONE);
    tick();
    checkCtl("b2b_retrigger", CTL_MDGO);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkCtl("b2b_wait", CTL_MDWAIT);
      tick();
    end
    applyStimulus(1'b1, 5'd4, 1'b0, 5'd0, 5'd4, 1'b1);
    checkCtl("b2b_done_luse", CTL_DONELU);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    checkCtl("b2b_idle", CTL_RUN);
    checkCount("b2b_count", 9);

    // Saturation at 4'hF
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd12, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checkCount("sat_mid", 10);
    for (int i = 0; i < 10; i++) tick();
    checkCount("sat_final", 15);
    checkCtl("sat_still_stalling", CTL_LUSE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
